// File: rtl/wb_arbiter.sv
// Two-requester register-file writeback arbiter: 1-cycle registered write port, x0 writes dropped.
// Tie policy: fixed priority to req0 by default, round-robin when WB_ARB_RR_EN is defined.
module wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ready,
  output logic              o_rw,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [DATA_W-1:0] o_rd,
  output logic              o_grant_id
);

  logic              last_grant_q, last_grant_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              grant_id_q, grant_id_d;

  logic              tie_pick1;
  logic              pick1;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Which requester wins when both are valid in the same cycle.
  always_comb begin
`ifdef WB_ARB_RR_EN
    tie_pick1 = ~last_grant_q;
`else
    tie_pick1 = 1'b0;
`endif
  end

  always_comb begin
    pick1        = i_req1_valid & (~i_req0_valid | tie_pick1);
    o_req0_ready = ~i_rst & i_req0_valid & ~pick1;
    o_req1_ready = ~i_rst & i_req1_valid & pick1;
    xfer         = o_req0_ready | o_req1_ready;
    sel_addr     = pick1 ? i_req1_addr : i_req0_addr;
    sel_data     = pick1 ? i_req1_data : i_req0_data;
  end

  // Address/data/id only move on a real write so they hold across idle and x0 cycles.
  always_comb begin
    last_grant_d = last_grant_q;
    rw_d         = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_d         = rd_q;
    grant_id_d   = grant_id_q;
    if (xfer) begin
      last_grant_d = pick1;
      if (sel_addr != '0) begin
        rw_d       = 1'b1;
        rd_addr_d  = sel_addr;
        rd_d       = sel_data;
        grant_id_d = pick1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant_q <= 1'b1;
      rw_q         <= 1'b0;
      rd_addr_q    <= '0;
      rd_q         <= '0;
      grant_id_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rw_q         <= rw_d;
      rd_addr_q    <= rd_addr_d;
      rd_q         <= rd_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign o_rw       = rw_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_rd       = rd_q;
  assign o_grant_id = grant_id_q;

  a_one_ready: assert property (@(posedge i_clk) !(o_req0_ready && o_req1_ready));

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against a cycle-level behavioural model of the writeback rules.
module tb_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          v0, v1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          rdy0, rdy1;
  logic          rw;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd;
  logic          gid;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int           m_last;
  bit           m_rw;
  int           m_addr, m_gid;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_regs [32];
  logic [DW-1:0] d_regs [32];
  bit           m_rdy0, m_rdy1;

  // Requester-side pending requests for random stimulus
  bit           p0, p1;
  logic [AW-1:0] pa0, pa1;
  logic [DW-1:0] pd0, pd1;

  wb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .i_req0_addr(a0), .i_req0_data(d0), .o_req0_ready(rdy0),
    .i_req1_valid(v1), .i_req1_addr(a1), .i_req1_data(d1), .o_req1_ready(rdy1),
    .o_rw(rw), .o_rd_addr(rd_addr), .o_rd(rd), .o_grant_id(gid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tie_winner();
`ifdef WB_ARB_RR_EN
    return (m_last == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // One clock cycle: drive, check readies mid-cycle, step model, check registered outputs.
  task automatic cycle(input bit r, input bit iv0, input int ia0, input logic [DW-1:0] id0,
                       input bit iv1, input int ia1, input logic [DW-1:0] id1);
    int win;
    @(negedge clk);
    rst = r; v0 = iv0; a0 = AW'(ia0); d0 = id0; v1 = iv1; a1 = AW'(ia1); d1 = id1;
    #1;
    win = -1;
    if (!r) begin
      if (iv0 && iv1) win = tie_winner();
      else if (iv0)   win = 0;
      else if (iv1)   win = 1;
    end
    m_rdy0 = (win == 0);
    m_rdy1 = (win == 1);
    check("ready0", 64'(rdy0), 64'(m_rdy0));
    check("ready1", 64'(rdy1), 64'(m_rdy1));
    @(posedge clk);
    if (r) begin
      m_rw = 0; m_addr = 0; m_data = '0; m_gid = 0; m_last = 1;
    end else if (win >= 0) begin
      int wa;
      logic [DW-1:0] wd;
      wa = (win == 0) ? ia0 : ia1;
      wd = (win == 0) ? id0 : id1;
      m_last = win;
      m_rw = (wa != 0);
      if (wa != 0) begin
        m_addr = wa; m_data = wd; m_gid = win;
        m_regs[wa] = wd;
      end
    end else begin
      m_rw = 0;
    end
    #1;
    if (rw === 1'b1) d_regs[rd_addr] = rd;
    check("o_rw", 64'(rw), 64'(m_rw));
    check("o_rd_addr", 64'(rd_addr), 64'(m_addr));
    check("o_rd", 64'(rd), 64'(m_data));
    check("o_grant_id", 64'(gid), 64'(m_gid));
  endtask

  initial begin
    rst = 1'b1; v0 = 0; v1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    m_last = 1; m_rw = 0; m_addr = 0; m_data = '0; m_gid = 0;
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; d_regs[i] = '0; end

    // Reset state
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);

    // Single write, then idle
    cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    check("single_rd", 64'(rd), 64'hDEADBEEF);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("single_rw_off", 64'(rw), 64'd0);

    // x0 discard
    cycle(0, 0, 0, 0, 1, 0, 32'h1234);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Held tie for four cycles
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 1, 1, 32'h11, 1, 2, 32'h22);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Same address from both requesters right after reset
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 7, 32'hA, 1, 7, 32'hB);
    cycle(0, 0, 0, 0, 1, 7, 32'hB);
    check("same_addr_final", 64'(rd), 64'hB);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Reset after a transfer; request held through reset
    cycle(0, 1, 3, 32'h33, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 9, 32'h99);
    cycle(1, 0, 0, 0, 1, 9, 32'h99);
    cycle(0, 0, 0, 0, 1, 9, 32'h99);
    check("post_rst_grant", 64'(gid), 64'd1);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Random traffic; requesters hold until granted
    p0 = 0; p1 = 0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int c = 0; c < 3000; c++) begin
      bit r;
      if (!p0 && $urandom_range(2) == 0) begin
        p0 = 1; pa0 = AW'(($urandom_range(7) == 0) ? 0 : $urandom_range(31)); pd0 = $urandom;
      end
      if (!p1 && $urandom_range(2) == 0) begin
        p1 = 1; pa1 = AW'(($urandom_range(7) == 0) ? 0 : $urandom_range(31)); pd1 = $urandom;
      end
      r = ($urandom_range(59) == 0);
      cycle(r, p0, int'(pa0), pd0, p1, int'(pa1), pd1);
      if (m_rdy0) p0 = 0;
      if (m_rdy1) p1 = 0;
    end
    cycle(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 32; i++) check($sformatf("regfile[%0d]", i), 64'(d_regs[i]), 64'(m_regs[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
